// File: rtl/sine_nco_if.sv
// Sample stream between the sine NCO (master) and the audio/PWM sample sink (slave).
interface sine_nco_if #(
    parameter int DATA_W = 21
);
    logic                     sample_valid;
    logic                     sample_ready;
    logic signed [DATA_W-1:0] sample_data;

    modport master (output sample_valid, output sample_data, input sample_ready);
    modport slave  (input sample_valid, input sample_data, output sample_ready);
endinterface

// File: rtl/sine_nco.sv
// Sine NCO: phase accumulator sequencing a dual-port 256x21 sine LUT, one sample per 3 cycles.
// Define SINE_NCO_INTERP_EN to interpolate linearly between idx and idx+1 using LUT port B.
module sine_nco #(
    parameter int PHASE_W = 32,
    parameter int FRAC_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic                inc_wr,
    input  logic [PHASE_W-1:0]  inc_din,
    input  logic                phase_clr,
    sine_nco_if.master          smp,
    output logic                lut_ena,
    output logic [7:0]          lut_addra,
    input  logic signed [20:0]  lut_douta,
    output logic                lut_enb,
    output logic [7:0]          lut_addrb,
    input  logic signed [20:0]  lut_doutb
);
    localparam int DATA_W = 21;
    localparam int PROD_W = FRAC_W + 23;

    typedef enum logic [1:0] {IDLE, READ, CAPT, OUT} state_t;

    state_t               state, state_nxt;
    logic [PHASE_W-1:0]   phase, inc;
    logic                 rd, capt, adv, handshake;
    logic signed [DATA_W-1:0] sample_calc;

    // Floor-rounded linear interpolation a + (b-a)*frac/2^FRAC_W; result lies between a and b.
    function automatic logic signed [DATA_W-1:0] interp(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b,
        input logic        [FRAC_W-1:0] frac
    );
        logic signed [DATA_W:0]   d;
        logic signed [PROD_W-1:0] de, fe, ae, p, sum;
        d   = {b[DATA_W-1], b} - {a[DATA_W-1], a};
        de  = {{(FRAC_W+1){d[DATA_W]}}, d};
        fe  = {23'b0, frac};
        ae  = {{(FRAC_W+2){a[DATA_W-1]}}, a};
        p   = de * fe;
        sum = (p >>> FRAC_W) + ae;
        return sum[DATA_W-1:0];
    endfunction

    assign handshake = smp.sample_valid & smp.sample_ready;
    assign lut_addra = phase[PHASE_W-1 -: 8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (run) state_nxt = READ;
            READ:    state_nxt = CAPT;
            CAPT:    state_nxt = OUT;
            OUT:     if (handshake) state_nxt = run ? READ : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd   = (state == READ);
        capt = (state == CAPT);
        adv  = (state == OUT) && handshake;
    end

`ifdef SINE_NCO_INTERP_EN
    logic [FRAC_W-1:0] frac_p1;

    assign lut_enb   = rd;
    assign lut_addrb = lut_addra + 8'd1;

    // Fraction is latched with the LUT read so a phase_clr cannot disturb the in-flight sample.
    always_ff @(posedge clk) begin
        if (rd) frac_p1 <= phase[PHASE_W-9 -: FRAC_W];
    end

    assign sample_calc = interp(lut_douta, lut_doutb, frac_p1);
`else
    logic unused_doutb;

    assign lut_enb      = 1'b0;
    assign lut_addrb    = 8'd0;
    assign unused_doutb = ^lut_doutb;
    assign sample_calc  = lut_douta;
`endif

    assign lut_ena = rd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= '0;
            inc   <= '0;
        end else begin
            if (phase_clr) phase <= '0;
            else if (adv)  phase <= phase + inc;
            if (inc_wr)    inc   <= inc_din;
        end
    end

    // CAPT -> OUT boundary: sample registered and held until the sink takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            smp.sample_valid <= 1'b0;
            smp.sample_data  <= '0;
        end else if (capt) begin
            smp.sample_valid <= 1'b1;
            smp.sample_data  <= sample_calc;
        end else if (adv) begin
            smp.sample_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sine_nco.sv
// Directed bench for sine_nco with a mem[i]=i*1000 registered LUT model; honours SINE_NCO_INTERP_EN.
module tb_sine_nco;
    logic               clk = 1'b0;
    logic               rst, run, inc_wr, phase_clr;
    logic [31:0]        inc_din;
    logic               lut_ena, lut_enb;
    logic [7:0]         lut_addra, lut_addrb;
    logic signed [20:0] lut_douta, lut_doutb;

    sine_nco_if #(.DATA_W(21)) smp();

    sine_nco #(.PHASE_W(32), .FRAC_W(8)) dut (
        .clk(clk), .rst(rst), .run(run), .inc_wr(inc_wr), .inc_din(inc_din),
        .phase_clr(phase_clr), .smp(smp),
        .lut_ena(lut_ena), .lut_addra(lut_addra), .lut_douta(lut_douta),
        .lut_enb(lut_enb), .lut_addrb(lut_addrb), .lut_doutb(lut_doutb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (lut_ena) lut_douta <= 21'(int'(lut_addra) * 1000);
        if (lut_enb) lut_doutb <= 21'(int'(lut_addrb) * 1000);
    end

    typedef struct {
        logic [31:0] inc;
        int          exp_s[4];
    } vec_t;

    vec_t vecs[4];
    int   n_checks = 0;
    int   n_fail   = 0;
`ifdef SINE_NCO_INTERP_EN
    int   exp_addrb0 = 1;
    int   exp_enb_rd = 1;
`else
    int   exp_addrb0 = 0;
    int   exp_enb_rd = 0;
`endif

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int budget, output int edges);
        edges = 0;
        while (edges < budget) begin
            tick();
            edges++;
            if (smp.sample_valid === 1'b1) return;
        end
        edges = -1;
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; inc_wr = 1'b0; phase_clr = 1'b0;
        inc_din = '0; smp.sample_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic write_inc(input logic [31:0] v);
        inc_din = v; inc_wr = 1'b1;
        tick();
        inc_wr = 1'b0;
    endtask

    int e;
    int held;

    initial begin
        vecs[0].inc = 32'h0100_0000; vecs[0].exp_s = '{0, 1000, 2000, 3000};
`ifdef SINE_NCO_INTERP_EN
        vecs[1].inc = 32'h0080_0000; vecs[1].exp_s = '{0, 500, 1000, 1500};
        vecs[2].inc = 32'hFF80_0000; vecs[2].exp_s = '{0, 127500, 255000, 254500};
        vecs[3].inc = 32'hFF01_0000; vecs[3].exp_s = '{0, 254003, 254007, 253011};
`else
        vecs[1].inc = 32'h0080_0000; vecs[1].exp_s = '{0, 0, 1000, 1000};
        vecs[2].inc = 32'hFF80_0000; vecs[2].exp_s = '{0, 255000, 255000, 254000};
        vecs[3].inc = 32'hFF01_0000; vecs[3].exp_s = '{0, 255000, 254000, 253000};
`endif

        do_reset();
        check("rst_valid", int'(smp.sample_valid), 0);
        check("rst_data", int'(smp.sample_data), 0);
        check("rst_ena", int'(lut_ena), 0);
        check("rst_enb", int'(lut_enb), 0);
        check("rst_addra", int'(lut_addra), 0);
        check("rst_addrb", int'(lut_addrb), exp_addrb0);

        for (int i = 0; i < 4; i++) begin
            do_reset();
            write_inc(vecs[i].inc);
            smp.sample_ready = 1'b1;
            run = 1'b1;
            for (int k = 0; k < 4; k++) begin
                wait_valid(8, e);
                check($sformatf("v%0d_lat%0d", i, k), e, 3);
                check($sformatf("v%0d_s%0d", i, k), int'(smp.sample_data), vecs[i].exp_s[k]);
                if (k == 3) run = 1'b0;
            end
            tick();
            tick();
            check($sformatf("v%0d_idle_valid", i), int'(smp.sample_valid), 0);
        end

        // Stall the second sample with ready low.
        do_reset();
        write_inc(32'h0100_0000);
        smp.sample_ready = 1'b1;
        run = 1'b1;
        wait_valid(8, e);
        check("stall_s0", int'(smp.sample_data), 0);
        tick();
        smp.sample_ready = 1'b0;
        wait_valid(8, e);
        check("stall_s1", int'(smp.sample_data), 1000);
        held = int'(smp.sample_data);
        for (int c = 0; c < 10; c++) begin
            tick();
            check($sformatf("stall_valid%0d", c), int'(smp.sample_valid), 1);
            check($sformatf("stall_data%0d", c), int'(smp.sample_data), held);
            check($sformatf("stall_ena%0d", c), int'(lut_ena) + int'(lut_enb), 0);
            check($sformatf("stall_addra%0d", c), int'(lut_addra), 1);
        end
        smp.sample_ready = 1'b1;
        tick();
        check("stall_release_valid", int'(smp.sample_valid), 0);
        check("stall_release_addra", int'(lut_addra), 2);

        // Clear plus increment write on the same cycle as a handshake.
        wait_valid(8, e);
        check("clr_pre_s", int'(smp.sample_data), 2000);
        inc_wr = 1'b1; inc_din = 32'h0200_0000; phase_clr = 1'b1;
        tick();
        inc_wr = 1'b0; phase_clr = 1'b0;
        check("clr_addra", int'(lut_addra), 0);
        wait_valid(8, e);
        check("clr_s0", int'(smp.sample_data), 0);
        wait_valid(8, e);
        check("clr_s1_newinc", int'(smp.sample_data), 2000);

        // Reset asserted while the FSM is in CAPT.
        do_reset();
        write_inc(32'h0100_0000);
        smp.sample_ready = 1'b1;
        run = 1'b1;
        wait_valid(8, e);
        wait_valid(8, e);
        check("capt_pre_s", int'(smp.sample_data), 1000);
        tick();
        check("read_ena", int'(lut_ena), 1);
        check("read_enb", int'(lut_enb), exp_enb_rd);
        tick();
        check("capt_hold_data", int'(smp.sample_data), 1000);
        check("capt_ena", int'(lut_ena), 0);
        rst = 1'b1;
        #1;
        check("arst_valid", int'(smp.sample_valid), 0);
        check("arst_data", int'(smp.sample_data), 0);
        check("arst_addra", int'(lut_addra), 0);
        check("arst_addrb", int'(lut_addrb), exp_addrb0);
        tick();
        check("arst_no_sample", int'(smp.sample_valid), 0);
        rst = 1'b0;
        wait_valid(8, e);
        check("arst_post_lat", e, 3);
        check("arst_post_s", int'(smp.sample_data), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end
endmodule
